// File: rtl/rc5_round_engine.sv
// Iterative RC5-w/r/b round engine: one round per clock, per-transaction
// direction and round count, valid/ready handshakes on both sides.
module rc5_round_engine #(
    parameter int unsigned W     = 16,
    parameter int unsigned R_MAX = 16,
    parameter int unsigned RW    = 5
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [2*W*(R_MAX+1)-1:0] subkeys,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_decrypt,
    input  logic [RW-1:0]            in_rounds,
    input  logic [2*W-1:0]           in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [2*W-1:0]           out_data,
    output logic                     out_err
);

    localparam int unsigned LW = $clog2(W);
    localparam int unsigned NS = 2 * (R_MAX + 1);
    localparam int unsigned SW = $clog2(NS);
    localparam logic [RW-1:0] RMaxW = RW'(R_MAX);

    typedef enum logic [1:0] {StIdle, StRound, StPost, StDone} state_e;

    state_e         r_state, w_state_nxt;
    logic [W-1:0]   r_a, r_b;
    logic [RW-1:0]  r_cnt, r_nrounds;
    logic           r_mode;
    logic [2*W-1:0] r_out_data;
    logic           r_out_err;

    logic [W-1:0]   w_s [NS];
    logic [SW-1:0]  w_ie, w_io;
    logic [W-1:0]   w_enc_a, w_enc_b, w_dec_a, w_dec_b;
    logic           w_accept, w_too_big, w_last;

    function automatic logic [W-1:0] rotl(input logic [W-1:0] x, input logic [LW-1:0] s);
        logic [2*W-1:0] t;
        t = {x, x} << s;
        return t[2*W-1:W];
    endfunction

    function automatic logic [W-1:0] rotr(input logic [W-1:0] x, input logic [LW-1:0] s);
        logic [2*W-1:0] t;
        t = {x, x} >> s;
        return t[W-1:0];
    endfunction

    for (genvar g = 0; g < NS; g++) begin : g_sk
        assign w_s[g] = subkeys[g*W +: W];
    end

    // Subkey pair for the current round: S[2i], S[2i+1]
    assign w_ie = SW'({r_cnt, 1'b0});
    assign w_io = SW'({r_cnt, 1'b1});

    assign w_accept  = in_valid && in_ready;
    assign w_too_big = in_rounds > RMaxW;
    // Encrypt counts up to N, decrypt counts down to 1
    assign w_last    = r_mode ? (r_cnt == RW'(1)) : (r_cnt == r_nrounds);

    // One RC5 round in each direction
    always_comb begin
        w_enc_a = rotl(r_a ^ r_b, r_b[LW-1:0]) + w_s[w_ie];
        w_enc_b = rotl(r_b ^ w_enc_a, w_enc_a[LW-1:0]) + w_s[w_io];
        w_dec_b = rotr(r_b - w_s[w_io], r_a[LW-1:0]) ^ r_a;
        w_dec_a = rotr(r_a - w_s[w_ie], w_dec_b[LW-1:0]) ^ w_dec_b;
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            StIdle: begin
                if (w_accept) begin
                    if (w_too_big)                w_state_nxt = StDone;
                    else if (in_rounds == '0)     w_state_nxt = StPost;
                    else                          w_state_nxt = StRound;
                end
            end
            StRound: if (w_last)    w_state_nxt = StPost;
            StPost:                 w_state_nxt = StDone;
            StDone:  if (out_ready) w_state_nxt = StIdle;
            default:                w_state_nxt = StIdle;
        endcase
    end

    // Handshake outputs; in_ready is held low while reset is asserted
    always_comb begin
        in_ready  = rst_n && (r_state == StIdle);
        out_valid = (r_state == StDone);
        out_data  = r_out_data;
        out_err   = r_out_err;
    end

    // Datapath registers: load/whiten on accept, round, unwhiten and publish
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a        <= '0;
            r_b        <= '0;
            r_cnt      <= '0;
            r_nrounds  <= '0;
            r_mode     <= 1'b0;
            r_out_data <= '0;
            r_out_err  <= 1'b0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (w_accept) begin
                        r_mode    <= in_decrypt;
                        r_nrounds <= in_rounds;
                        if (w_too_big) begin
                            r_out_data <= in_data;
                            r_out_err  <= 1'b1;
                        end else if (in_decrypt) begin
                            r_a   <= in_data[W-1:0];
                            r_b   <= in_data[2*W-1:W];
                            r_cnt <= in_rounds;
                        end else begin
                            r_a   <= in_data[W-1:0] + w_s[0];
                            r_b   <= in_data[2*W-1:W] + w_s[1];
                            r_cnt <= RW'(1);
                        end
                    end
                end
                StRound: begin
                    if (r_mode) begin
                        r_a <= w_dec_a;
                        r_b <= w_dec_b;
                        // Hold cnt on the last round so it never leaves 1..R_MAX
                        if (!w_last) r_cnt <= r_cnt - RW'(1);
                    end else begin
                        r_a <= w_enc_a;
                        r_b <= w_enc_b;
                        if (!w_last) r_cnt <= r_cnt + RW'(1);
                    end
                end
                StPost: begin
                    r_out_data <= r_mode ? {r_b - w_s[1], r_a - w_s[0]} : {r_b, r_a};
                    r_out_err  <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_rc5_round_engine.sv
// Directed bench for rc5_round_engine at W=16, R_MAX=16.
module tb_rc5_round_engine;

    localparam int W     = 16;
    localparam int R_MAX = 16;
    localparam int RW    = 5;
    localparam int NS    = 2 * (R_MAX + 1);

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic [2*W*(R_MAX+1)-1:0] subkeys;
    logic                     in_valid = 1'b0;
    logic                     in_ready;
    logic                     in_decrypt = 1'b0;
    logic [RW-1:0]            in_rounds = '0;
    logic [2*W-1:0]           in_data = '0;
    logic                     out_valid;
    logic                     out_ready = 1'b0;
    logic [2*W-1:0]           out_data;
    logic                     out_err;

    logic [15:0] sk [NS];
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_comb begin
        subkeys = '0;
        for (int i = 0; i < NS; i++) subkeys[i*16 +: 16] = sk[i];
    end

    rc5_round_engine #(.W(W), .R_MAX(R_MAX), .RW(RW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .subkeys    (subkeys),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_decrypt (in_decrypt),
        .in_rounds  (in_rounds),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_err    (out_err)
    );

    // Bit-at-a-time rotate for the reference model
    function automatic logic [15:0] m_rotl(input logic [15:0] x, input logic [3:0] s);
        logic [15:0] y;
        y = x;
        for (int k = 0; k < int'(s); k++) y = {y[14:0], y[15]};
        return y;
    endfunction

    function automatic logic [31:0] rc5_enc(input logic [31:0] din, input int n);
        logic [15:0] a, b;
        a = din[15:0] + sk[0];
        b = din[31:16] + sk[1];
        for (int i = 1; i <= n; i++) begin
            a = m_rotl(a ^ b, b[3:0]) + sk[2*i];
            b = m_rotl(b ^ a, a[3:0]) + sk[2*i+1];
        end
        return {b, a};
    endfunction

    task automatic keys_zero();
        for (int i = 0; i < NS; i++) sk[i] = 16'h0000;
    endtask

    task automatic keys_random();
        for (int i = 0; i < NS; i++) sk[i] = 16'($urandom);
    endtask

    // Waits for in_ready, issues one request, waits for the result and
    // completes the output handshake. lat = clock edges after the accept edge
    // before out_valid is seen.
    task automatic run_txn(input logic dec, input int n, input logic [31:0] din,
                           output logic [31:0] dout, output logic derr, output int lat);
        int guard;
        guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout in_ready=%0b required 1", in_ready);
        end
        in_valid   = 1'b1;
        in_decrypt = dec;
        in_rounds  = RW'(n);
        in_data    = din;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        if (!out_valid) begin
            total++; bad++;
            $display("FAIL result_timeout out_valid=%0b required 1", out_valid);
        end
        dout = out_data;
        derr = out_err;
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready got=%0b exp=0", in_ready); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_out_valid got=%0b exp=0", out_valid); end
        total++;
        if (out_data !== 32'h0) begin bad++; $display("FAIL rst_out_data got=%h exp=0", out_data); end
        total++;
        if (out_err !== 1'b0) begin bad++; $display("FAIL rst_out_err got=%0b exp=0", out_err); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_release_in_ready got=%0b exp=1", in_ready); end
    endtask

    task automatic test_zero_rounds();
        logic [31:0] d;
        logic e;
        int lat;
        keys_zero();
        sk[0] = 16'h1111;
        sk[1] = 16'h2222;
        run_txn(1'b0, 0, 32'h0002_0001, d, e, lat);
        total++;
        if (d !== 32'h2224_1112) begin bad++; $display("FAIL n0_enc_data got=%h exp=22241112", d); end
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL n0_enc_err got=%0b exp=0", e); end
        total++;
        if (lat != 1) begin bad++; $display("FAIL n0_enc_latency got=%0d exp=1", lat); end
        run_txn(1'b1, 0, 32'h2224_1112, d, e, lat);
        total++;
        if (d !== 32'h0002_0001) begin bad++; $display("FAIL n0_dec_data got=%h exp=00020001", d); end
        total++;
        if (lat != 1) begin bad++; $display("FAIL n0_dec_latency got=%0d exp=1", lat); end
    endtask

    task automatic test_one_round();
        logic [31:0] d;
        logic e;
        int lat;
        keys_zero();
        run_txn(1'b0, 1, 32'h0002_0001, d, e, lat);
        total++;
        if (d !== 32'hE000_000C) begin bad++; $display("FAIL n1_enc_data got=%h exp=e000000c", d); end
        total++;
        if (lat != 2) begin bad++; $display("FAIL n1_enc_latency got=%0d exp=2", lat); end
    endtask

    task automatic test_random_blocks();
        logic [31:0] pt, ct, rt, exp_ct;
        logic e;
        int lat;
        keys_random();
        for (int k = 0; k < 100; k++) begin
            pt = $urandom;
            exp_ct = rc5_enc(pt, 12);
            run_txn(1'b0, 12, pt, ct, e, lat);
            total++;
            if (ct !== exp_ct) begin
                bad++; $display("FAIL rand_enc[%0d] got=%h exp=%h", k, ct, exp_ct);
            end
            run_txn(1'b1, 12, ct, rt, e, lat);
            total++;
            if (rt !== pt) begin
                bad++; $display("FAIL rand_dec[%0d] got=%h exp=%h", k, rt, pt);
            end
        end
        total++;
        if (lat != 13) begin bad++; $display("FAIL n12_latency got=%0d exp=13", lat); end
    endtask

    task automatic test_error_path();
        logic [31:0] d, exp_d;
        logic e;
        int lat;
        run_txn(1'b0, 17, 32'hABCD_1234, d, e, lat);
        total++;
        if (e !== 1'b1) begin bad++; $display("FAIL err_flag got=%0b exp=1", e); end
        total++;
        if (d !== 32'hABCD_1234) begin bad++; $display("FAIL err_data got=%h exp=abcd1234", d); end
        total++;
        if (lat != 0) begin bad++; $display("FAIL err_latency got=%0d exp=0", lat); end
        exp_d = rc5_enc(32'h5A5A_0F0F, 2);
        run_txn(1'b0, 2, 32'h5A5A_0F0F, d, e, lat);
        total++;
        if (d !== exp_d) begin bad++; $display("FAIL after_err_data got=%h exp=%h", d, exp_d); end
        total++;
        if (e !== 1'b0) begin bad++; $display("FAIL after_err_flag got=%0b exp=0", e); end
    endtask

    task automatic test_backpressure();
        logic [31:0] first, exp_d;
        int lat, hs, stable_bad;
        exp_d = rc5_enc(32'h1357_9BDF, 16);
        @(negedge clk);
        in_valid   = 1'b1;
        in_decrypt = 1'b0;
        in_rounds  = 5'd16;
        in_data    = 32'h1357_9BDF;
        @(posedge clk);
        #1 in_valid = 1'b0;
        lat = 0;
        @(negedge clk);
        while (!out_valid && lat < 100) begin
            @(negedge clk);
            lat++;
        end
        total++;
        if (lat != 17) begin bad++; $display("FAIL bp_latency got=%0d exp=17", lat); end
        first = out_data;
        total++;
        if (first !== exp_d) begin bad++; $display("FAIL bp_data got=%h exp=%h", first, exp_d); end
        // Offer a competing request while the result is stalled
        in_valid = 1'b1;
        in_data  = 32'hFFFF_FFFF;
        stable_bad = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b1 || out_data !== first || in_ready !== 1'b0) stable_bad++;
        end
        in_valid = 1'b0;
        total++;
        if (stable_bad != 0) begin
            bad++; $display("FAIL bp_stable bad_cycles=%0d exp=0", stable_bad);
        end
        out_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 5; c++) begin
            if (out_valid && out_ready) hs++;
            @(negedge clk);
        end
        out_ready = 1'b0;
        total++;
        if (hs != 1) begin bad++; $display("FAIL bp_handshakes got=%0d exp=1", hs); end
    endtask

    task automatic test_reset_mid_round();
        logic [31:0] d, exp_d;
        logic e;
        int lat, spurious;
        @(negedge clk);
        in_valid   = 1'b1;
        in_decrypt = 1'b0;
        in_rounds  = 5'd8;
        in_data    = 32'h0BAD_F00D;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        total++;
        if (out_data !== 32'h0) begin bad++; $display("FAIL midrst_out_data got=%h exp=0", out_data); end
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL midrst_out_valid got=%0b exp=0", out_valid); end
        total++;
        if (out_err !== 1'b0) begin bad++; $display("FAIL midrst_out_err got=%0b exp=0", out_err); end
        total++;
        if (in_ready !== 1'b0) begin bad++; $display("FAIL midrst_in_ready got=%0b exp=0", in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_release_ready got=%0b exp=1", in_ready); end
        spurious = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (out_valid !== 1'b0) spurious++;
        end
        total++;
        if (spurious != 0) begin bad++; $display("FAIL midrst_aborted valid_cycles=%0d exp=0", spurious); end
        exp_d = rc5_enc(32'h0BAD_F00D, 8);
        run_txn(1'b0, 8, 32'h0BAD_F00D, d, e, lat);
        total++;
        if (d !== exp_d) begin bad++; $display("FAIL midrst_fresh_data got=%h exp=%h", d, exp_d); end
        total++;
        if (lat != 9) begin bad++; $display("FAIL midrst_fresh_latency got=%0d exp=9", lat); end
    endtask

    initial begin
        keys_zero();
        test_reset();
        test_zero_rounds();
        test_one_round();
        test_random_blocks();
        test_error_path();
        test_backpressure();
        test_reset_mid_round();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
